fifo_to_tx: RTL and testbench
=============================

Name: fifo_to_tx

Overview:
- Drain stage that sits directly downstream of the per-channel Tx request FIFOs.
- Pops buffered c0 (read request), c1 (write request) and c2 (MMIO response) entries and drives the host-facing CCI-P Tx port.
- Honours host c0/c1 almost-full back-pressure.
- Keeps multi-line c1 write packets contiguous.
- Maintains per-channel issued-packet counters for debug.

Parameters:
- CNT_WIDTH, 32, width of each per-channel issued-beat counter (wraps modulo 2^CNT_WIDTH).

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- in_fifo_c0_first  in  $bits(t_if_ccip_c0_Tx)  head entry of the c0 FIFO (show-ahead).
- in_fifo_c0_notEmpty  in  1  c0 FIFO holds at least one entry.
- out_fifo_c0_deq_en  out  1  pop the c0 FIFO this cycle.
- in_fifo_c1_first  in  $bits(t_if_ccip_c1_Tx)  head entry of the c1 FIFO.
- in_fifo_c1_notEmpty  in  1  c1 FIFO non-empty.
- out_fifo_c1_deq_en  out  1  pop the c1 FIFO.
- in_fifo_c2_first  in  $bits(t_if_ccip_c2_Tx)  head entry of the c2 FIFO.
- in_fifo_c2_notEmpty  in  1  c2 FIFO non-empty.
- out_fifo_c2_deq_en  out  1  pop the c2 FIFO.
- c0TxAlmFull  in  1  host c0 almost-full.
- c1TxAlmFull  in  1  host c1 almost-full.
- host_TxPort  out  $bits(t_if_ccip_Tx)  registered CCI-P Tx toward host.
- cnt_c0  out  CNT_WIDTH  c0 beats issued since reset.
- cnt_c1  out  CNT_WIDTH  c1 beats issued since reset.
- cnt_c2  out  CNT_WIDTH  c2 beats issued since reset.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - host_TxPort all-zero, so all valids are 0.
  - cnt_c0/1/2 = 0.
  - c1 state = IDLE, beat counter = 0.
  - All deq_en outputs are combinationally 0 while reset=1.
- Dequeue and latency:
  - deq_en is combinational and is only asserted when the matching notEmpty=1.
  - A popped head is registered onto host_TxPort.cN the next cycle with valid=1: latency exactly 1 cycle.
  - In a cycle with no pop, host_TxPort.cN is driven to zero. No beat is ever repeated.
- c0: out_fifo_c0_deq_en = notEmpty & ~c0TxAlmFull.
- c2: out_fifo_c2_deq_en = notEmpty. MMIO responses have no host back-pressure.
- c1 FSM:
  - IDLE:
    - deq when notEmpty & ~c1TxAlmFull.
    - If the popped head has hdr.sop=1 and cl_len != eCL_LEN_1, load remaining = cl_len (1 for 2-line, 3 for 4-line) and go to BURST.
    - Otherwise stay in IDLE.
  - BURST:
    - deq whenever notEmpty, ignoring c1TxAlmFull (host tolerates the bounded overrun; packets must not be split).
    - On each pop, decrement remaining; the pop that takes remaining from 1 to 0 returns to IDLE.
    - FIFO empty mid-burst: no pop, no output, state held; resume when data returns.
- Channels are independent. Any combination of c0/c1/c2 may issue in the same cycle.
- Counters: increment by 1 on each pop of their channel (c1 counts beats, not packets). Wrap silently at 2^CNT_WIDTH.
- Malformed input: a head with sop=0 while in IDLE is issued as a single beat, with no FSM change. Entries are not checked.
- Reset mid-operation:
  - Next cycle, the FSM returns to IDLE and the outputs and counters are zero.
  - A partially issued burst is abandoned. Upstream FIFOs are reset by the same signal.
- Almost-full is sampled combinationally in the pop cycle. An assertion stops new c0 pops, and new c1 packet starts, in that same cycle.

Test Plan:
1. Push one c0 read (mdata=0x12), both almost-fulls 0.
   - Required: out_fifo_c0_deq_en=1 in cycle N; host_TxPort.c0.valid=1 with mdata 0x12 in N+1, 0 in N+2; cnt_c0=1.
2. Queue 3 c0 entries with c0TxAlmFull=1 for 5 cycles, then drop it.
   - Required: no deq and c0.valid=0 throughout the hold; afterwards 3 consecutive valid beats; cnt_c0=3.
3. Queue a 4-line c1 write (sop=1, cl_len=eCL_LEN_4) followed by a 1-line write; raise c1TxAlmFull in the cycle after beat 1 pops.
   - Required: beats 2–4 still issue on consecutive cycles; the 1-line write is held until almost-full drops; cnt_c1=5 at the end.
4. 2-line c1 write whose second beat arrives 4 cycles late.
   - Required: FSM stays in BURST, c1.valid=0 during the gap; the second beat issues 1 cycle after it arrives; then IDLE.
5. c2 MMIO response with c0TxAlmFull=c1TxAlmFull=1.
   - Required: host_TxPort.c2.valid=1 exactly 1 cycle after the pop; cnt_c2=1.
6. Assert reset after beat 2 of a 4-line burst.
   - Required: next cycle all valids=0, counters=0, FSM in IDLE; a fresh 1-line write after reset issues normally.

Source files
------------

// File: rtl/fifo_to_tx_if.sv
// fifo_to_tx_if: CCI-P Tx types plus the FIFO-side / host-side bundle of the Tx drain stage
package ccip_pkg;
    typedef enum logic [1:0] {eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11} t_ccip_clLen;
    typedef struct packed {
        t_ccip_clLen cl_len;
        logic [3:0] req_type;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c0_ReqMemHdr;
    typedef struct packed {
        logic sop;
        t_ccip_clLen cl_len;
        logic [3:0] req_type;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c1_ReqMemHdr;
    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;
    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic valid;
    } t_if_ccip_c0_Tx;
    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0] data;
        logic valid;
    } t_if_ccip_c1_Tx;
    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic [63:0] data;
        logic valid;
    } t_if_ccip_c2_Tx;
    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;
endpackage

interface fifo_to_tx_if #(parameter int CNT_WIDTH = 32);
    import ccip_pkg::*;
    t_if_ccip_c0_Tx in_fifo_c0_first;
    logic in_fifo_c0_notEmpty;
    logic out_fifo_c0_deq_en;
    t_if_ccip_c1_Tx in_fifo_c1_first;
    logic in_fifo_c1_notEmpty;
    logic out_fifo_c1_deq_en;
    t_if_ccip_c2_Tx in_fifo_c2_first;
    logic in_fifo_c2_notEmpty;
    logic out_fifo_c2_deq_en;
    logic c0TxAlmFull;
    logic c1TxAlmFull;
    t_if_ccip_Tx host_TxPort;
    logic [CNT_WIDTH-1:0] cnt_c0;
    logic [CNT_WIDTH-1:0] cnt_c1;
    logic [CNT_WIDTH-1:0] cnt_c2;
    modport master (
        input in_fifo_c0_first, in_fifo_c0_notEmpty, in_fifo_c1_first, in_fifo_c1_notEmpty,
        input in_fifo_c2_first, in_fifo_c2_notEmpty, c0TxAlmFull, c1TxAlmFull,
        output out_fifo_c0_deq_en, out_fifo_c1_deq_en, out_fifo_c2_deq_en,
        output host_TxPort, cnt_c0, cnt_c1, cnt_c2
    );
    modport slave (
        output in_fifo_c0_first, in_fifo_c0_notEmpty, in_fifo_c1_first, in_fifo_c1_notEmpty,
        output in_fifo_c2_first, in_fifo_c2_notEmpty, c0TxAlmFull, c1TxAlmFull,
        input out_fifo_c0_deq_en, out_fifo_c1_deq_en, out_fifo_c2_deq_en,
        input host_TxPort, cnt_c0, cnt_c1, cnt_c2
    );
endinterface

// File: rtl/fifo_to_tx.sv
// fifo_to_tx: drains c0/c1/c2 Tx FIFOs onto a registered CCI-P Tx port, keeping c1 bursts contiguous
module fifo_to_tx
    import ccip_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input logic clk,
    input logic reset,
    fifo_to_tx_if.master bus
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state;
    logic [1:0] remaining;
    logic [CNT_WIDTH-1:0] cnt0, cnt1, cnt2;
    t_if_ccip_Tx tx;
    t_if_ccip_c0_Tx c0_beat;
    t_if_ccip_c1_Tx c1_beat;
    t_if_ccip_c2_Tx c2_beat;
    logic deq0, deq1, deq2, starts_burst;
    // once a packet has started, its remaining beats ignore almost-full so it is never split
    assign deq0 = ~reset & bus.in_fifo_c0_notEmpty & ~bus.c0TxAlmFull;
    assign deq1 = ~reset & bus.in_fifo_c1_notEmpty & (state == BURST | ~bus.c1TxAlmFull);
    assign deq2 = ~reset & bus.in_fifo_c2_notEmpty;
    assign starts_burst = bus.in_fifo_c1_first.hdr.sop & (bus.in_fifo_c1_first.hdr.cl_len != eCL_LEN_1);
    always_comb begin
        c0_beat = bus.in_fifo_c0_first;
        c0_beat.valid = 1'b1;
        c1_beat = bus.in_fifo_c1_first;
        c1_beat.valid = 1'b1;
        c2_beat = bus.in_fifo_c2_first;
        c2_beat.valid = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tx <= '0;
            state <= IDLE;
            remaining <= '0;
            cnt0 <= '0;
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            tx.c0 <= deq0 ? c0_beat : '0;
            tx.c1 <= deq1 ? c1_beat : '0;
            tx.c2 <= deq2 ? c2_beat : '0;
            cnt0 <= cnt0 + CNT_WIDTH'(deq0);
            cnt1 <= cnt1 + CNT_WIDTH'(deq1);
            cnt2 <= cnt2 + CNT_WIDTH'(deq2);
            if (deq1 && state == IDLE && starts_burst) begin
                state <= BURST;
                remaining <= bus.in_fifo_c1_first.hdr.cl_len;
            end else if (deq1 && state == BURST) begin
                remaining <= remaining - 2'd1;
                if (remaining == 2'd1) state <= IDLE;
            end
        end
    end
    assign bus.out_fifo_c0_deq_en = deq0;
    assign bus.out_fifo_c1_deq_en = deq1;
    assign bus.out_fifo_c2_deq_en = deq2;
    assign bus.host_TxPort = tx;
    assign bus.cnt_c0 = cnt0;
    assign bus.cnt_c1 = cnt1;
    assign bus.cnt_c2 = cnt2;
endmodule

// File: tb/tb_fifo_to_tx.sv
// tb_fifo_to_tx: FIFO model + reference model + scoreboard bench for fifo_to_tx
module tb_fifo_to_tx;
    import ccip_pkg::*;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    fifo_to_tx_if #(.CNT_WIDTH(32)) bus();
    fifo_to_tx #(.CNT_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    int checks = 0;
    int errors = 0;
    t_if_ccip_c0_Tx q0[$], sb0[$];
    t_if_ccip_c1_Tx q1[$], sb1[$];
    t_if_ccip_c2_Tx q2[$], sb2[$];
    bit m_burst = 1'b0;
    int m_rem = 0;
    logic [31:0] m_cnt0 = '0, m_cnt1 = '0, m_cnt2 = '0;
    typedef struct {
        logic rst, ne0, ne1, ne2, af0, af1, d0, d1, d2;
    } vec_t;
    vec_t tv[8];

    task automatic check(string name, logic [1023:0] act, logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic t_if_ccip_c0_Tx mk0(logic [15:0] md);
        t_if_ccip_c0_Tx e = '0;
        e.hdr.mdata = md;
        e.hdr.address = {26'd0, md};
        e.valid = 1'b1;
        return e;
    endfunction

    function automatic t_if_ccip_c1_Tx mk1(logic sop, t_ccip_clLen len, logic [15:0] md);
        t_if_ccip_c1_Tx e = '0;
        e.hdr.sop = sop;
        e.hdr.cl_len = len;
        e.hdr.mdata = md;
        e.hdr.req_type = 4'h1;
        e.data = {32{md}};
        e.valid = 1'b1;
        return e;
    endfunction

    function automatic t_if_ccip_c2_Tx mk2(logic [8:0] tid, logic [63:0] d);
        t_if_ccip_c2_Tx e = '0;
        e.hdr.tid = tid;
        e.data = d;
        e.valid = 1'b1;
        return e;
    endfunction

    task automatic drive();
        bus.in_fifo_c0_notEmpty = q0.size() != 0;
        bus.in_fifo_c1_notEmpty = q1.size() != 0;
        bus.in_fifo_c2_notEmpty = q2.size() != 0;
        bus.in_fifo_c0_first = q0.size() != 0 ? q0[0] : '0;
        bus.in_fifo_c1_first = q1.size() != 0 ? q1[0] : '0;
        bus.in_fifo_c2_first = q2.size() != 0 ? q2[0] : '0;
    endtask

    // one clock: check pops against the model, advance the model, then check registered outputs
    task automatic cycle();
        logic e0, e1, e2;
        t_if_ccip_c0_Tx v0;
        t_if_ccip_c1_Tx v1;
        t_if_ccip_c2_Tx v2;
        drive();
        #1;
        e0 = !reset && q0.size() != 0 && !bus.c0TxAlmFull;
        e1 = !reset && q1.size() != 0 && (m_burst || !bus.c1TxAlmFull);
        e2 = !reset && q2.size() != 0;
        check("deq_c0", 1024'(bus.out_fifo_c0_deq_en), 1024'(e0));
        check("deq_c1", 1024'(bus.out_fifo_c1_deq_en), 1024'(e1));
        check("deq_c2", 1024'(bus.out_fifo_c2_deq_en), 1024'(e2));
        @(posedge clk);
        if (reset) begin
            m_burst = 1'b0;
            m_rem = 0;
            m_cnt0 = '0;
            m_cnt1 = '0;
            m_cnt2 = '0;
            sb0.push_back('0);
            sb1.push_back('0);
            sb2.push_back('0);
        end else begin
            v0 = '0;
            v1 = '0;
            v2 = '0;
            if (e0) begin
                v0 = q0.pop_front();
                v0.valid = 1'b1;
                m_cnt0++;
            end
            if (e2) begin
                v2 = q2.pop_front();
                v2.valid = 1'b1;
                m_cnt2++;
            end
            if (e1) begin
                v1 = q1.pop_front();
                v1.valid = 1'b1;
                m_cnt1++;
                if (m_burst) begin
                    m_rem--;
                    if (m_rem == 0) m_burst = 1'b0;
                end else if (v1.hdr.sop && v1.hdr.cl_len != eCL_LEN_1) begin
                    m_burst = 1'b1;
                    m_rem = v1.hdr.cl_len == eCL_LEN_2 ? 1 : 3;
                end
            end
            sb0.push_back(v0);
            sb1.push_back(v1);
            sb2.push_back(v2);
        end
        #1;
        check("tx_c0", 1024'(bus.host_TxPort.c0), 1024'(sb0.pop_front()));
        check("tx_c1", 1024'(bus.host_TxPort.c1), 1024'(sb1.pop_front()));
        check("tx_c2", 1024'(bus.host_TxPort.c2), 1024'(sb2.pop_front()));
        check("cnt_c0", 1024'(bus.cnt_c0), 1024'(m_cnt0));
        check("cnt_c1", 1024'(bus.cnt_c1), 1024'(m_cnt1));
        check("cnt_c2", 1024'(bus.cnt_c2), 1024'(m_cnt2));
    endtask

    initial begin
        tv[0] = '{0, 1, 1, 1, 0, 0, 1, 1, 1};
        tv[1] = '{0, 1, 1, 1, 1, 1, 0, 0, 1};
        tv[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[3] = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
        tv[4] = '{0, 0, 1, 0, 1, 0, 0, 1, 0};
        tv[5] = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
        tv[6] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        tv[7] = '{0, 0, 0, 1, 1, 1, 0, 0, 1};
        reset = 1'b1;
        bus.c0TxAlmFull = 1'b0;
        bus.c1TxAlmFull = 1'b0;
        drive();
        repeat (2) cycle();
        reset = 1'b0;
        cycle();
        // combinational dequeue table, applied between edges in IDLE with empty FIFOs
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            reset = tv[i].rst;
            bus.in_fifo_c0_notEmpty = tv[i].ne0;
            bus.in_fifo_c1_notEmpty = tv[i].ne1;
            bus.in_fifo_c2_notEmpty = tv[i].ne2;
            bus.c0TxAlmFull = tv[i].af0;
            bus.c1TxAlmFull = tv[i].af1;
            #1;
            check($sformatf("vec%0d deq_c0", i), 1024'(bus.out_fifo_c0_deq_en), 1024'(tv[i].d0));
            check($sformatf("vec%0d deq_c1", i), 1024'(bus.out_fifo_c1_deq_en), 1024'(tv[i].d1));
            check($sformatf("vec%0d deq_c2", i), 1024'(bus.out_fifo_c2_deq_en), 1024'(tv[i].d2));
            reset = 1'b0;
            bus.c0TxAlmFull = 1'b0;
            bus.c1TxAlmFull = 1'b0;
            drive();
        end
        // single c0 read
        q0.push_back(mk0(16'h12));
        repeat (3) cycle();
        check("t1 cnt_c0", 1024'(bus.cnt_c0), 1024'(1));
        // c0 held by almost-full, then drained back to back
        bus.c0TxAlmFull = 1'b1;
        for (int i = 0; i < 3; i++) q0.push_back(mk0(16'h20 + 16'(i)));
        repeat (5) cycle();
        bus.c0TxAlmFull = 1'b0;
        repeat (4) cycle();
        check("t2 cnt_c0", 1024'(bus.cnt_c0), 1024'(4));
        // 4-line burst survives almost-full, following 1-line write waits
        q1.push_back(mk1(1'b1, eCL_LEN_4, 16'h40));
        for (int i = 1; i < 4; i++) q1.push_back(mk1(1'b0, eCL_LEN_4, 16'h40 + 16'(i)));
        q1.push_back(mk1(1'b1, eCL_LEN_1, 16'h50));
        cycle();
        bus.c1TxAlmFull = 1'b1;
        repeat (6) cycle();
        bus.c1TxAlmFull = 1'b0;
        repeat (2) cycle();
        check("t3 cnt_c1", 1024'(bus.cnt_c1), 1024'(5));
        // 2-line burst with a late second beat, then back in IDLE
        q1.push_back(mk1(1'b1, eCL_LEN_2, 16'h60));
        cycle();
        bus.c1TxAlmFull = 1'b1;
        repeat (4) cycle();
        q1.push_back(mk1(1'b0, eCL_LEN_2, 16'h61));
        repeat (2) cycle();
        q1.push_back(mk1(1'b1, eCL_LEN_1, 16'h62));
        repeat (2) cycle();
        bus.c1TxAlmFull = 1'b0;
        repeat (2) cycle();
        check("t4 cnt_c1", 1024'(bus.cnt_c1), 1024'(8));
        // MMIO response ignores both almost-fulls
        bus.c0TxAlmFull = 1'b1;
        bus.c1TxAlmFull = 1'b1;
        q2.push_back(mk2(9'h1a5, 64'hdead_beef_0123_4567));
        q0.push_back(mk0(16'h70));
        repeat (3) cycle();
        check("t5 cnt_c2", 1024'(bus.cnt_c2), 1024'(1));
        bus.c0TxAlmFull = 1'b0;
        bus.c1TxAlmFull = 1'b0;
        repeat (2) cycle();
        // reset in the middle of a 4-line burst
        q1.push_back(mk1(1'b1, eCL_LEN_4, 16'h80));
        for (int i = 1; i < 4; i++) q1.push_back(mk1(1'b0, eCL_LEN_4, 16'h80 + 16'(i)));
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        q1.delete();
        reset = 1'b0;
        cycle();
        check("t6 cnt_c0", 1024'(bus.cnt_c0), 1024'(0));
        check("t6 cnt_c1", 1024'(bus.cnt_c1), 1024'(0));
        q1.push_back(mk1(1'b1, eCL_LEN_1, 16'h90));
        repeat (2) cycle();
        check("t6 cnt_c1 after", 1024'(bus.cnt_c1), 1024'(1));
        // malformed sop=0 head in IDLE goes out as a single beat
        q1.push_back(mk1(1'b0, eCL_LEN_4, 16'ha0));
        q1.push_back(mk1(1'b1, eCL_LEN_1, 16'ha1));
        cycle();
        bus.c1TxAlmFull = 1'b1;
        repeat (2) cycle();
        bus.c1TxAlmFull = 1'b0;
        repeat (2) cycle();
        check("t7 cnt_c1", 1024'(bus.cnt_c1), 1024'(3));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
